lincomb_seq_v: RTL and testbench

- Parametrised, sequential successor to the team's fixed-coefficient signed calculator.
- Computes o_f = KA*A +/- KB*B with runtime signed coefficients and a runtime add/subtract mode.
- Uses one shared shift-add magnitude multiplier, run serially over both products, with a start/ready/valid handshake.
- Optional saturation to a narrower output width with a flag.
- Sits between the operand switch/register front-end and the display/result register.

---
 rtl/lincomb_seq_v_pkg.sv | 16 +
 rtl/lincomb_seq_v_if.sv | 30 +++
 rtl/lincomb_seq_v_mul.sv | 44 ++++
 rtl/lincomb_seq_v.sv | 131 +++++++++++++
 tb/tb_lincomb_seq_v.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/lincomb_seq_v_pkg.sv
// Shared definitions for the sequential linear-combination unit:
// FSM state encoding and the exact (unsaturated) result width.
package lincomb_seq_v_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL_A = 2'd1,
        S_MUL_B = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int full_w(input int w, input int cw);
        return w + cw + 1;
    endfunction

endpackage

// File: rtl/lincomb_seq_v_if.sv
// Request/response bundle between the operand front-end (master)
// and the lincomb_seq_v engine (slave).
interface lincomb_seq_v_if
    import lincomb_seq_v_pkg::*;
#(
    parameter int W  = 5,
    parameter int CW = 5,
    parameter int OW = full_w(W, CW)
);
    logic                 i_start;
    logic                 i_sub;
    logic signed [W-1:0]  i_as;
    logic signed [W-1:0]  i_bs;
    logic signed [CW-1:0] i_ka;
    logic signed [CW-1:0] i_kb;
    logic                 o_ready;
    logic                 o_valid;
    logic signed [OW-1:0] o_f;
    logic                 o_sat;

    modport master (
        output i_start, i_sub, i_as, i_bs, i_ka, i_kb,
        input  o_ready, o_valid, o_f, o_sat
    );

    modport slave (
        input  i_start, i_sub, i_as, i_bs, i_ka, i_kb,
        output o_ready, o_valid, o_f, o_sat
    );
endinterface

// File: rtl/lincomb_seq_v_mul.sv
// Unsigned W x CW shift-add multiplier, LSB-first over the coefficient.
// The load edge performs the first step, so o_done rises CW cycles after load.
module seq_mag_mul_v #(
    parameter int W  = 5,
    parameter int CW = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [W-1:0]    i_a_mag,
    input  logic [CW-1:0]   i_k_mag,
    output logic [W+CW-1:0] o_prod,
    output logic            o_done
);
    localparam int PW   = W + CW;
    localparam int CNTW = $clog2(CW + 1);

    logic [PW-1:0]   prod_q;
    logic [PW-1:0]   mcand_q;
    logic [CW-1:0]   k_q;
    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else if (i_load) begin
            prod_q  <= i_k_mag[0] ? PW'(i_a_mag) : '0;
            mcand_q <= PW'(i_a_mag) << 1;
            k_q     <= i_k_mag >> 1;
            cnt_q   <= CNTW'(1);
        end else if (cnt_q != CNTW'(CW)) begin
            prod_q  <= prod_q + (k_q[0] ? mcand_q : '0);
            mcand_q <= mcand_q << 1;
            k_q     <= k_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign o_prod = prod_q;
    assign o_done = (cnt_q == CNTW'(CW));
endmodule

// File: rtl/lincomb_seq_v.sv
// Sequential KA*A +/- KB*B with runtime signed coefficients, one shared
// magnitude multiplier used twice, and optional clipping to OW bits.
module lincomb_seq_v
    import lincomb_seq_v_pkg::*;
#(
    parameter int W  = 5,
    parameter int CW = 5,
    parameter int OW = full_w(W, CW)
) (
    input logic            i_clk,
    input logic            i_rst,
    lincomb_seq_v_if.slave bus
);
    localparam int FW = full_w(W, CW);
    localparam int PW = W + CW;
    localparam logic signed [FW-1:0] MAXV = FW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [FW-1:0] MINV = ~MAXV;

    function automatic logic [W-1:0] mag_op(input logic signed [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [CW-1:0] mag_k(input logic signed [CW-1:0] v);
        return v[CW-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic signed [FW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
        logic signed [FW-1:0] sx;
        sx = signed'({1'b0, p});
        return neg ? -sx : sx;
    endfunction

    // {clipped, value}: with OW == FW the bounds can never be crossed
    function automatic logic [OW:0] sat_map(input logic signed [FW-1:0] v);
        if (v > MAXV)      return {1'b1, MAXV[OW-1:0]};
        else if (v < MINV) return {1'b1, MINV[OW-1:0]};
        else               return {1'b0, v[OW-1:0]};
    endfunction

    state_e               state_q;
    logic                 sub_q;
    logic                 aneg_q;
    logic                 bneg_q;
    logic [W-1:0]         bmag_q;
    logic [CW-1:0]        kbmag_q;
    logic signed [FW-1:0] acc_q;
    logic signed [FW-1:0] acc_d;
    logic                 valid_q;
    logic                 sat_q;
    logic signed [OW-1:0] f_q;

    logic                 mul_load;
    logic [W-1:0]         mul_a;
    logic [CW-1:0]        mul_k;
    logic [PW-1:0]        mul_prod;
    logic                 mul_done;
    logic signed [FW-1:0] pb;

    // The multiplier is loaded with A on accept and reloaded with B when A finishes
    always_comb begin
        mul_load = 1'b0;
        mul_a    = mag_op(bus.i_as);
        mul_k    = mag_k(bus.i_ka);
        if (state_q == S_IDLE && bus.i_start) begin
            mul_load = 1'b1;
        end else if (state_q == S_MUL_A && mul_done) begin
            mul_load = 1'b1;
            mul_a    = bmag_q;
            mul_k    = kbmag_q;
        end
    end

    seq_mag_mul_v #(.W(W), .CW(CW)) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (mul_load),
        .i_a_mag (mul_a),
        .i_k_mag (mul_k),
        .o_prod  (mul_prod),
        .o_done  (mul_done)
    );

    assign pb    = apply_sign(mul_prod, bneg_q);
    assign acc_d = sub_q ? (acc_q - pb) : (acc_q + pb);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sub_q   <= 1'b0;
            aneg_q  <= 1'b0;
            bneg_q  <= 1'b0;
            bmag_q  <= '0;
            kbmag_q <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            f_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.i_start) begin
                    sub_q   <= bus.i_sub;
                    // a zero product is always treated as positive
                    aneg_q  <= (bus.i_as[W-1] ^ bus.i_ka[CW-1]) && (bus.i_as != '0) && (bus.i_ka != '0);
                    bneg_q  <= (bus.i_bs[W-1] ^ bus.i_kb[CW-1]) && (bus.i_bs != '0) && (bus.i_kb != '0);
                    bmag_q  <= mag_op(bus.i_bs);
                    kbmag_q <= mag_k(bus.i_kb);
                    acc_q   <= '0;
                    state_q <= S_MUL_A;
                end
                S_MUL_A: if (mul_done) begin
                    acc_q   <= apply_sign(mul_prod, aneg_q);
                    state_q <= S_MUL_B;
                end
                S_MUL_B: if (mul_done) begin
                    acc_q          <= acc_d;
                    {sat_q, f_q}   <= sat_map(acc_d);
                    valid_q        <= 1'b1;
                    state_q        <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_f     = f_q;
    assign bus.o_sat   = sat_q;
endmodule

// File: tb/tb_lincomb_seq_v.sv
// Bench for lincomb_seq_v: a full-width and an OW=9 instance checked
// against an integer reference of KA*A +/- KB*B with clipping.
module tb_lincomb_seq_v;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    lincomb_seq_v_if #(.W(5), .CW(5), .OW(11)) if0 ();
    lincomb_seq_v_if #(.W(5), .CW(5), .OW(9))  if1 ();

    lincomb_seq_v #(.W(5), .CW(5), .OW(11)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    lincomb_seq_v #(.W(5), .CW(5), .OW(9))  u1 (.i_clk(clk), .i_rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int a, input int b, input int ka, input int kb,
                                  input int sub, input int ow, output int f, output int s);
        int v;
        int mx;
        int mn;
        v  = ka * a + (sub != 0 ? -(kb * b) : kb * b);
        mx = (1 << (ow - 1)) - 1;
        mn = -(1 << (ow - 1));
        s  = 0;
        f  = v;
        if (v > mx) begin f = mx; s = 1; end
        if (v < mn) begin f = mn; s = 1; end
    endfunction

    function automatic int rnd5();
        return int'($urandom_range(0, 31)) - 16;
    endfunction

    task automatic drive(input int a, input int b, input int ka, input int kb, input int sub);
        if0.i_as = 5'(a);  if0.i_bs = 5'(b);  if0.i_ka = 5'(ka);  if0.i_kb = 5'(kb);  if0.i_sub = sub[0];
        if1.i_as = 5'(a);  if1.i_bs = 5'(b);  if1.i_ka = 5'(ka);  if1.i_kb = 5'(kb);  if1.i_sub = sub[0];
    endtask

    task automatic sample(input int sel, output logic v, output logic r,
                          output logic signed [31:0] f, output logic s);
        if (sel != 0) begin v = if1.o_valid; r = if1.o_ready; f = if1.o_f; s = if1.o_sat; end
        else          begin v = if0.o_valid; r = if0.o_ready; f = if0.o_f; s = if0.o_sat; end
    endtask

    task automatic run_op(input int sel, input int a, input int b, input int ka, input int kb,
                          input int sub, input string tag);
        int ef, es, c, busy_bad;
        logic v, r, s;
        logic signed [31:0] f;
        model(a, b, ka, kb, sub, (sel != 0) ? 9 : 11, ef, es);
        @(negedge clk);
        drive(a, b, ka, kb, sub);
        if (sel != 0) if1.i_start = 1'b1; else if0.i_start = 1'b1;
        @(posedge clk);
        #1;
        if0.i_start = 1'b0;
        if1.i_start = 1'b0;
        drive(rnd5(), rnd5(), rnd5(), rnd5(), 1);
        c = 0; busy_bad = 0; v = 1'b0; f = '0; s = 1'b0; r = 1'b0;
        while (!v && c < 30) begin
            @(negedge clk);
            c++;
            sample(sel, v, r, f, s);
            if (r) busy_bad++;
        end
        chk({tag, "_latency"}, c, 11);
        chk({tag, "_f"}, f, ef);
        chk({tag, "_sat"}, s, es);
        chk({tag, "_busy"}, busy_bad, 0);
        @(negedge clk);
        sample(sel, v, r, f, s);
        chk({tag, "_ready_back"}, r, 1);
        chk({tag, "_valid_pulse"}, v, 0);
    endtask

    initial begin
        int qf[$];
        int qs[$];
        int qc[$];
        int nacc, nval, ef, es, a, b, ka, kb, sub, vcnt;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        if0.i_start = 1'b0;
        if1.i_start = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_ready0", if0.o_ready, 1);
        chk("rst_valid0", if0.o_valid, 0);
        chk("rst_f0", if0.o_f, 0);
        chk("rst_sat0", if0.o_sat, 0);
        chk("rst_ready1", if1.o_ready, 1);
        chk("rst_f1", if1.o_f, 0);
        rst = 1'b0;

        run_op(0, 15, 15, 6, 11, 1, "dflt");
        run_op(0, -16, -16, -16, -16, 0, "ext_add");
        run_op(0, -16, -16, -16, -16, 1, "ext_sub");
        run_op(0, -16, 15, 15, -16, 0, "ext_mix");
        run_op(1, 15, -16, 15, 15, 1, "sat_hi");
        run_op(1, -16, 15, 15, 15, 1, "sat_lo");
        run_op(1, -16, 15, 15, 15, 0, "narrow_mix");
        run_op(1, 1, 0, 1, 9, 0, "narrow_small");
        run_op(0, -16, 7, 0, -3, 1, "zero_ka");
        run_op(0, 0, 0, 0, 0, 0, "all_zero");

        for (int i = 0; i < 24; i++) begin
            run_op(i % 2, rnd5(), rnd5(), rnd5(), rnd5(), int'($urandom_range(0, 1)), "rnd");
        end

        // start held high with fresh operands every cycle
        nacc = 0;
        nval = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (if0.o_valid) begin
                nval++;
                if (qf.size() == 0) begin
                    chk("hs_extra_valid", 1, 0);
                end else begin
                    chk("hs_f", if0.o_f, qf.pop_front());
                    chk("hs_sat", if0.o_sat, qs.pop_front());
                    chk("hs_latency", cyc - qc.pop_front(), 11);
                end
            end
            if (cyc < 49) begin
                a = rnd5(); b = rnd5(); ka = rnd5(); kb = rnd5(); sub = int'($urandom_range(0, 1));
                drive(a, b, ka, kb, sub);
                if0.i_start = 1'b1;
                if (if0.o_ready) begin
                    model(a, b, ka, kb, sub, 11, ef, es);
                    qf.push_back(ef);
                    qs.push_back(es);
                    qc.push_back(cyc);
                    nacc++;
                end
            end else begin
                if0.i_start = 1'b0;
            end
        end
        chk("hs_accepts", nacc, 5);
        chk("hs_valids", nval, 5);
        chk("hs_pending", qf.size(), 0);

        // reset in the middle of an operation
        @(negedge clk);
        drive(9, -7, 13, 5, 0);
        if0.i_start = 1'b1;
        @(posedge clk);
        #1;
        if0.i_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", if0.o_ready, 1);
        chk("midrst_valid", if0.o_valid, 0);
        chk("midrst_f", if0.o_f, 0);
        chk("midrst_sat", if0.o_sat, 0);
        vcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (if0.o_valid) vcnt++;
        end
        chk("midrst_no_valid", vcnt, 0);
        run_op(0, 9, -7, 13, 5, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
